mult32_final_cpa_pipe: RTL



---
 rtl/mult32_final_cpa_pipe_pkg.sv | 18 +
 rtl/mult32_final_cpa_pipe_cpa32.sv | 18 +
 rtl/mult32_final_cpa_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mult32_final_cpa_pipe_pkg.sv
// Shared constants and payload types for the multiplier final carry-propagate stage.
package mult32_final_cpa_pipe_pkg;

    localparam int unsigned MUL_W     = 32;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned MUL_TAG_W = 5;

    // Stage-1 payload: resolved low half plus the still-redundant high half.
    // The tag travels beside this struct so TAG_W can be overridden per instance.
    typedef struct packed {
        logic [MUL_W-1:0] lo;
        logic             c32;
        logic [MUL_W-1:0] sum_hi;
        logic [MUL_W-1:0] carry_hi;
        logic             sel_hi;
    } s1_payload_t;

endpackage

// File: rtl/mult32_final_cpa_pipe_cpa32.sv
// 32-bit carry-propagate adder with carry in/out; behavioural for now,
// intended to be swapped for a prefix adder without touching the pipeline.
module cpa32
    import mult32_final_cpa_pipe_pkg::*;
(
    input  logic [MUL_W-1:0] a_i,
    input  logic [MUL_W-1:0] b_i,
    input  logic             cin_i,
    output logic [MUL_W-1:0] sum_o,
    output logic             cout_o
);

    // Widen by one bit so the carry out falls out of the add.
    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{MUL_W{1'b0}}, cin_i};
    end

endmodule

// File: rtl/mult32_final_cpa_pipe.sv
// Final carry-propagate stage of the 32x32 multiplier: resolves the redundant
// sum/carry pair into a binary product over two pipelined 32-bit halves and
// returns the selected word with its tag under a valid/ready handshake.
module mult32_final_cpa_pipe
    import mult32_final_cpa_pipe_pkg::*;
#(
    parameter int unsigned TAG_W = MUL_TAG_W,
    parameter int unsigned SPLIT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_sum,
    input  logic [63:0]       in_carry,
    input  logic              in_sel_hi,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_ovf
);

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    s1_payload_t       s1_pay_q, s1_pay_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic [MUL_W-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_ovf_q, out_ovf_d;

    logic              s2_free;
    logic              s1_adv;
    logic              accept;

    logic [MUL_W-1:0]  lo_sum;
    logic              lo_cout;
    logic [MUL_W-1:0]  hi_sum;
    logic              hi_cout;

    cpa32 u_cpa_lo (
        .a_i    (in_sum[SPLIT-1:0]),
        .b_i    (in_carry[SPLIT-1:0]),
        .cin_i  (1'b0),
        .sum_o  (lo_sum),
        .cout_o (lo_cout)
    );

    cpa32 u_cpa_hi (
        .a_i    (s1_pay_q.sum_hi),
        .b_i    (s1_pay_q.carry_hi),
        .cin_i  (s1_pay_q.c32),
        .sum_o  (hi_sum),
        .cout_o (hi_cout)
    );

    // Handshake: a stage moves only when the one downstream of it frees;
    // in_ready is derived from state and out_ready only, never from in_valid.
    always_comb begin
        s2_free    = ~s2_valid_q | out_ready;
        s1_adv     = s1_valid_q & s2_free;
        in_ready   = ~s1_valid_q | s2_free;
        accept     = in_valid & in_ready;
        s1_valid_d = accept | (s1_valid_q & ~s1_adv);
        s2_valid_d = s1_adv | (s2_valid_q & ~out_ready);
    end

    // Payload next-state: registers load only on advance, otherwise hold.
    always_comb begin
        s1_pay_d     = s1_pay_q;
        s1_tag_d     = s1_tag_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_ovf_d    = out_ovf_q;
        if (accept) begin
            s1_pay_d.lo       = lo_sum;
            s1_pay_d.c32      = lo_cout;
            s1_pay_d.sum_hi   = in_sum[PROD_W-1:SPLIT];
            s1_pay_d.carry_hi = in_carry[PROD_W-1:SPLIT];
            s1_pay_d.sel_hi   = in_sel_hi;
            s1_tag_d          = in_tag;
        end
        if (s1_adv) begin
            out_result_d = s1_pay_q.sel_hi ? hi_sum : s1_pay_q.lo;
            out_tag_d    = s1_tag_q;
            out_ovf_d    = hi_cout;
        end
    end

    // Pipeline registers with synchronous reset that discards in-flight entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_pay_q     <= '0;
            s1_tag_q     <= '0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s1_pay_q     <= s1_pay_d;
            s1_tag_q     <= s1_tag_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    // Outputs come straight from stage-2 registers.
    always_comb begin
        out_valid  = s2_valid_q;
        out_result = out_result_q;
        out_tag    = out_tag_q;
        out_ovf    = out_ovf_q;
    end

endmodule
